max7219_word_scheduler: RTL and testbench
=========================================

Name: max7219_word_scheduler

Overview:
- Sequences a byte-level SPI master to drive a MAX7219 8x8 LED matrix.
- Issues 16-bit register words (address byte, then data byte) framed by a dedicated LOAD/CS line that stays low across both bytes.
- Runs the power-up init sequence, then arbitrates between frame-refresh requests (8 row words) and intensity-change requests (1 word).
- Sits between the pet-state/pattern logic and spi_master.

Parameters:
- STARTUP_CYCLES, 1000: clocks to wait after reset release before the first word.
- GAP_CYCLES, 4: minimum clocks load_n stays high between words (min 1).
- INTENSITY_INIT, 4'hA: intensity written during init.
- SCAN_LIMIT, 3'd7: scan-limit value written during init.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-low
- frame_req  input  1  1-cycle pulse: display frame_data
- frame_data  input  64  row i = frame_data[8*i+7:8*i], written to digit register i+1
- int_req  input  1  1-cycle pulse: set intensity
- int_value  input  4  new intensity
- spi_data  output  8  byte to spi_master.data_in
- spi_start  output  1  to spi_master.start
- spi_busy  input  1  from spi_master.busy
- spi_avail  input  1  from spi_master.avail; 1-cycle pulse when a byte completes
- load_n  output  1  MAX7219 LOAD/CS, low for a whole 16-bit word
- init_done  output  1  high after init and the first frame complete
- sched_busy  output  1  high whenever not in IDLE
- frame_done  output  1  1-cycle pulse after the last row word of a frame

Behaviour:
- Reset (reset low, async) values: spi_data=0, spi_start=0, load_n=1, init_done=0, sched_busy=1, frame_done=0.
- Reset also: shadow frame=0, shadow intensity=INTENSITY_INIT, both pending flags cleared, startup counter=0.
- Reset mid-word aborts immediately; load_n returns high asynchronously.
- Top FSM: STARTUP -> INIT -> FRAME -> IDLE; IDLE -> FRAME | INTEN; FRAME/INTEN -> IDLE.
- STARTUP: count STARTUP_CYCLES clocks, then go to INIT.
- INIT: send 5 words in order: 0C01, 0900, 0A(0,INTENSITY_INIT), 0B(0,SCAN_LIMIT), 0F00. Then go to FRAME, which clears the display with the zero shadow; init_done rises on that frame's frame_done cycle and stays high.
- FRAME: words (01,row0) .. (08,row7) from a snapshot of the shadow frame taken on FRAME entry. Then pulse frame_done and go to IDLE.
- INTEN: one word (0A, 0,shadow_int), then IDLE.
- Request capture (any state):
  - frame_req copies frame_data into the shadow and sets frame_pend.
  - int_req copies int_value and sets int_pend.
  - A repeat request before service overwrites the shadow; the last value wins and only one pending flag is kept.
  - A request landing on the same cycle the FSM consumes its flag re-sets the flag (a new transaction follows).
- Arbitration in IDLE: int_pend beats frame_pend. The flag clears on entering the serving state. With neither flag set, stay in IDLE with sched_busy=0.
- Word sub-FSM: LOW -> HI -> WAIT_HI -> LO -> WAIT_LO -> GAP.
  - LOW: load_n<=0, 1 cycle.
  - HI: wait for !spi_busy, then drive spi_data=address, spi_start=1.
  - WAIT_HI: hold spi_start and spi_data until the spi_avail pulse, then spi_start<=0.
  - LO: as HI with the data byte.
  - WAIT_LO: on spi_avail, spi_start<=0, load_n<=1.
  - GAP: keep load_n high for GAP_CYCLES, then take the next word or return to the top FSM.
- spi_data changes only while spi_start=0.
- load_n never rises between the two bytes of a word.
- No timeout: a missing spi_avail stalls the FSM.

Test Plan:
- Release reset, STARTUP_CYCLES=10, SPI model with 16-clk bytes -> exactly 10 clocks idle; SPI bytes 0C,01,09,00,0A,0A,0B,07,0F,00, then 01,00..08,00; load_n low for exactly 5+8 windows, each covering 2 bytes; init_done rises with frame_done.
- After init, frame_req with frame_data=64'hFF818181818181FF -> bytes 01 FF 02 81 ... 07 81 08 FF; one frame_done pulse; sched_busy back to 0.
- During a frame, pulse int_req (int_value=3) and frame_req (data=0) on the same cycle -> current frame completes, then word 0A03, then a frame of zeros.
- Two frame_req pulses (A, then B) before service -> only frame B is sent, with one frame_done.
- Assert reset low while the WAIT_LO byte is in flight -> load_n=1 and spi_start=0 asynchronously; after release the full init replays.
- Hold spi_busy=1 for 50 clocks in HI -> spi_start stays 0 and spi_data stays stable; the send proceeds on the first cycle spi_busy=0.

Source files
------------

// File: rtl/max7219_word_scheduler.sv
// Sequences 16-bit MAX7219 register words (address byte, data byte) over a byte-wide SPI master:
// power-up init, display clear, then frame refreshes and intensity updates.
module max7219_word_scheduler #(
   parameter int unsigned StartupCycles = 1000,
   parameter int unsigned GapCycles     = 4,
   parameter logic [3:0]  IntensityInit = 4'hA,
   parameter logic [2:0]  ScanLimit     = 3'd7
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        frame_req_i,
   input  logic [63:0] frame_data_i,
   input  logic        int_req_i,
   input  logic [3:0]  int_value_i,
   output logic [7:0]  spi_data_o,
   output logic        spi_start_o,
   input  logic        spi_busy_i,
   input  logic        spi_avail_i,
   output logic        load_n_o,
   output logic        init_done_o,
   output logic        sched_busy_o,
   output logic        frame_done_o
);

   localparam int unsigned CntMax = (StartupCycles > GapCycles) ? StartupCycles : GapCycles;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam logic [CntW-1:0] StartupLast = CntW'(StartupCycles - 1);
   localparam logic [CntW-1:0] GapLast     = CntW'(GapCycles - 1);

   typedef enum logic [2:0] {StStartup, StInit, StFrame, StIdle, StInten} top_e;
   typedef enum logic [2:0] {WdIdle, WdLow, WdHi, WdWaitHi, WdLo, WdWaitLo, WdGap} word_e;

   top_e            top_q;
   word_e           word_q;
   logic [2:0]      idx_q;
   logic [CntW-1:0] cnt_q;
   logic [63:0]     frame_shadow_q;
   logic [63:0]     frame_snap_q;
   logic [3:0]      int_shadow_q;
   logic            frame_pend_q;
   logic            int_pend_q;
   logic [7:0]      spi_data_q;
   logic            spi_start_q;
   logic            load_n_q;
   logic            init_done_q;
   logic            frame_done_q;

   logic [7:0]      word_addr;
   logic [7:0]      word_data;
   logic            word_last;

   // Address/data of the word currently being sent, selected by serving state and word index.
   always_comb begin
      word_addr = 8'h00;
      word_data = 8'h00;
      word_last = 1'b0;
      unique case (top_q)
         StInit: begin
            word_last = (idx_q == 3'd4);
            case (idx_q)
               3'd0:    {word_addr, word_data} = 16'h0C01;
               3'd1:    {word_addr, word_data} = 16'h0900;
               3'd2:    {word_addr, word_data} = {8'h0A, 4'h0, IntensityInit};
               3'd3:    {word_addr, word_data} = {8'h0B, 5'h00, ScanLimit};
               default: {word_addr, word_data} = 16'h0F00;
            endcase
         end
         StFrame: begin
            word_last = (idx_q == 3'd7);
            word_addr = {5'd0, idx_q} + 8'd1;
            word_data = frame_snap_q[{idx_q, 3'b000} +: 8];
         end
         StInten: begin
            word_last = 1'b1;
            word_addr = 8'h0A;
            word_data = {4'h0, int_shadow_q};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         top_q          <= StStartup;
         word_q         <= WdIdle;
         idx_q          <= '0;
         cnt_q          <= '0;
         frame_shadow_q <= '0;
         frame_snap_q   <= '0;
         int_shadow_q   <= IntensityInit;
         frame_pend_q   <= 1'b0;
         int_pend_q     <= 1'b0;
         spi_data_q     <= '0;
         spi_start_q    <= 1'b0;
         load_n_q       <= 1'b1;
         init_done_q    <= 1'b0;
         frame_done_q   <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (word_q)
            WdIdle: begin
               unique case (top_q)
                  StStartup: begin
                     if (cnt_q == StartupLast) begin
                        top_q  <= StInit;
                        word_q <= WdLow;
                        idx_q  <= '0;
                        cnt_q  <= '0;
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end
                  StIdle: begin
                     if (int_pend_q) begin
                        top_q      <= StInten;
                        int_pend_q <= 1'b0;
                        word_q     <= WdLow;
                        idx_q      <= '0;
                     end else if (frame_pend_q) begin
                        top_q        <= StFrame;
                        frame_pend_q <= 1'b0;
                        frame_snap_q <= frame_shadow_q;
                        word_q       <= WdLow;
                        idx_q        <= '0;
                     end
                  end
                  default: ;
               endcase
            end
            WdLow: begin
               load_n_q <= 1'b0;
               word_q   <= WdHi;
            end
            WdHi: begin
               if (!spi_busy_i) begin
                  spi_data_q  <= word_addr;
                  spi_start_q <= 1'b1;
                  word_q      <= WdWaitHi;
               end
            end
            WdWaitHi: begin
               if (spi_avail_i) begin
                  spi_start_q <= 1'b0;
                  word_q      <= WdLo;
               end
            end
            WdLo: begin
               if (!spi_busy_i) begin
                  spi_data_q  <= word_data;
                  spi_start_q <= 1'b1;
                  word_q      <= WdWaitLo;
               end
            end
            WdWaitLo: begin
               if (spi_avail_i) begin
                  spi_start_q <= 1'b0;
                  load_n_q    <= 1'b1;
                  cnt_q       <= '0;
                  word_q      <= WdGap;
               end
            end
            WdGap: begin
               if (cnt_q == GapLast) begin
                  cnt_q <= '0;
                  if (!word_last) begin
                     idx_q  <= idx_q + 3'd1;
                     word_q <= WdLow;
                  end else begin
                     idx_q <= '0;
                     // Init always ends by clearing the display from the shadow frame.
                     if (top_q == StInit) begin
                        top_q        <= StFrame;
                        frame_snap_q <= frame_shadow_q;
                        frame_pend_q <= 1'b0;
                        word_q       <= WdLow;
                     end else begin
                        top_q  <= StIdle;
                        word_q <= WdIdle;
                        if (top_q == StFrame) begin
                           frame_done_q <= 1'b1;
                           init_done_q  <= 1'b1;
                        end
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: word_q <= WdIdle;
         endcase

         // Placed last so a request on the consuming cycle re-arms its flag.
         if (frame_req_i) begin
            frame_shadow_q <= frame_data_i;
            frame_pend_q   <= 1'b1;
         end
         if (int_req_i) begin
            int_shadow_q <= int_value_i;
            int_pend_q   <= 1'b1;
         end
      end
   end

   assign spi_data_o   = spi_data_q;
   assign spi_start_o  = spi_start_q;
   assign load_n_o     = load_n_q;
   assign init_done_o  = init_done_q;
   assign frame_done_o = frame_done_q;
   assign sched_busy_o = (top_q != StIdle);

endmodule

// File: tb/tb_max7219_word_scheduler.sv
// Scoreboard bench for max7219_word_scheduler with a 16-clock-per-byte SPI master model.
module tb_max7219_word_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        frame_req = 1'b0;
   logic [63:0] frame_data = '0;
   logic        int_req = 1'b0;
   logic [3:0]  int_value = '0;
   logic [7:0]  spi_data;
   logic        spi_start;
   logic        spi_busy;
   logic        spi_avail;
   logic        load_n;
   logic        init_done;
   logic        sched_busy;
   logic        frame_done;
   logic        hold_busy = 1'b0;

   logic [1:0]  m_state;
   logic [4:0]  m_cnt;
   logic        m_busy;

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q[$];
   int win_bytes = 0;
   int windows = 0;
   int fd_cnt = 0;
   int acc_cnt = 0;
   logic prev_load_n = 1'b1;
   logic prev_start = 1'b0;
   logic prev_init_done = 1'b0;
   logic [7:0] prev_data = '0;

   always #5 clk = ~clk;

   assign spi_busy = m_busy | hold_busy;

   max7219_word_scheduler #(
      .StartupCycles(10),
      .GapCycles    (4),
      .IntensityInit(4'hA),
      .ScanLimit    (3'd7)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .frame_req_i (frame_req),
      .frame_data_i(frame_data),
      .int_req_i   (int_req),
      .int_value_i (int_value),
      .spi_data_o  (spi_data),
      .spi_start_o (spi_start),
      .spi_busy_i  (spi_busy),
      .spi_avail_i (spi_avail),
      .load_n_o    (load_n),
      .init_done_o (init_done),
      .sched_busy_o(sched_busy),
      .frame_done_o(frame_done)
   );

   // SPI master model: accept when idle, 16 clocks busy, 1-cycle avail, 1 cycle recovery.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state   <= 2'd0;
         m_cnt     <= '0;
         m_busy    <= 1'b0;
         spi_avail <= 1'b0;
      end else begin
         case (m_state)
            2'd0: begin
               spi_avail <= 1'b0;
               if (spi_start) begin
                  m_state <= 2'd1;
                  m_busy  <= 1'b1;
                  m_cnt   <= '0;
               end
            end
            2'd1: begin
               m_cnt <= m_cnt + 5'd1;
               if (m_cnt == 5'd15) begin
                  m_busy    <= 1'b0;
                  spi_avail <= 1'b1;
                  m_state   <= 2'd2;
               end
            end
            default: begin
               spi_avail <= 1'b0;
               m_state   <= 2'd0;
            end
         endcase
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on every byte the SPI model accepts.
   always @(negedge clk) begin
      if (!rst_n) begin
         win_bytes      = 0;
         prev_load_n    = 1'b1;
         prev_start     = 1'b0;
         prev_init_done = 1'b0;
      end else begin
         if (prev_load_n && !load_n) win_bytes = 0;
         if (m_state == 2'd0 && spi_start) begin
            acc_cnt++;
            if (!load_n) win_bytes++;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_byte: got %0h, want none", spi_data);
            end else begin
               check("spi_byte", 64'(spi_data), 64'(exp_q.pop_front()));
            end
         end
         if (spi_start && load_n) check("start_inside_load_window", 64'(load_n), 64'd0);
         if (prev_start && spi_start && spi_data != prev_data)
            check("spi_data_stable_during_start", 64'(spi_data), 64'(prev_data));
         if (!prev_load_n && load_n) begin
            windows++;
            check("window_bytes", 64'(win_bytes), 64'd2);
         end
         if (init_done && !prev_init_done)
            check("init_done_rise_with_frame_done", 64'(frame_done), 64'd1);
         if (frame_done) begin
            fd_cnt++;
            check("init_done_at_frame_done", 64'(init_done), 64'd1);
         end
         prev_load_n    = load_n;
         prev_start     = spi_start;
         prev_data      = spi_data;
         prev_init_done = init_done;
      end
   end

   task automatic push_word(input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back(a);
      exp_q.push_back(d);
   endtask

   task automatic push_frame(input logic [63:0] f);
      for (int i = 0; i < 8; i++) push_word(8'(i + 1), f[8*i +: 8]);
   endtask

   task automatic push_init();
      push_word(8'h0C, 8'h01);
      push_word(8'h09, 8'h00);
      push_word(8'h0A, 8'h0A);
      push_word(8'h0B, 8'h07);
      push_word(8'h0F, 8'h00);
      push_frame(64'h0);
   endtask

   task automatic pulse_frame(input logic [63:0] d);
      @(negedge clk);
      frame_data = d;
      frame_req  = 1'b1;
      @(negedge clk);
      frame_req  = 1'b0;
   endtask

   task automatic wait_fd(input int target, input string name);
      int n = 0;
      while (fd_cnt < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(fd_cnt >= target), 64'd1);
   endtask

   task automatic check_reset_values();
      check("rst_spi_data", 64'(spi_data), 64'd0);
      check("rst_spi_start", 64'(spi_start), 64'd0);
      check("rst_load_n", 64'(load_n), 64'd1);
      check("rst_init_done", 64'(init_done), 64'd0);
      check("rst_sched_busy", 64'(sched_busy), 64'd1);
      check("rst_frame_done", 64'(frame_done), 64'd0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int fd0;
      int acc0;
      int n;
      logic early_low;
      logic bad_start;
      logic bad_data;
      logic [7:0] saved;

      // Reset and startup delay.
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values();
      push_init();
      #2 rst_n = 1'b1;
      early_low = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (!load_n || spi_start) early_low = 1'b1;
      end
      check("startup_idle_10_clocks", 64'(early_low), 64'd0);
      check("startup_init_done_low", 64'(init_done), 64'd0);
      @(negedge clk);
      check("first_load_n_fall", 64'(load_n), 64'd0);
      wait_fd(1, "init_frame_done");
      repeat (3) @(negedge clk);
      check("init_windows", 64'(windows), 64'd13);
      check("init_queue_empty", 64'(exp_q.size()), 64'd0);
      check("init_idle", 64'(sched_busy), 64'd0);
      check("init_done_held", 64'(init_done), 64'd1);

      // Border frame.
      fd0 = fd_cnt;
      push_frame(64'hFF818181818181FF);
      pulse_frame(64'hFF818181818181FF);
      wait_fd(fd0 + 1, "border_frame_done");
      repeat (5) @(negedge clk);
      check("border_one_frame_done", 64'(fd_cnt), 64'(fd0 + 1));
      check("border_queue_empty", 64'(exp_q.size()), 64'd0);
      check("border_idle", 64'(sched_busy), 64'd0);

      // Intensity + frame requested together mid-frame: intensity wins arbitration.
      fd0 = fd_cnt;
      push_frame(64'h0102030405060708);
      push_word(8'h0A, 8'h03);
      push_frame(64'h0);
      pulse_frame(64'h0102030405060708);
      repeat (100) @(negedge clk);
      check("mid_frame_busy", 64'(sched_busy), 64'd1);
      int_req    = 1'b1;
      int_value  = 4'h3;
      frame_req  = 1'b1;
      frame_data = 64'h0;
      @(negedge clk);
      int_req   = 1'b0;
      frame_req = 1'b0;
      wait_fd(fd0 + 2, "arb_two_frames");
      repeat (10) @(negedge clk);
      check("arb_frame_done_count", 64'(fd_cnt), 64'(fd0 + 2));
      check("arb_queue_empty", 64'(exp_q.size()), 64'd0);
      check("arb_idle", 64'(sched_busy), 64'd0);

      // Two frame requests before service: last one wins.
      fd0 = fd_cnt;
      push_word(8'h0A, 8'h05);
      push_frame(64'h8040201008040201);
      @(negedge clk);
      int_req   = 1'b1;
      int_value = 4'h5;
      @(negedge clk);
      int_req    = 1'b0;
      frame_req  = 1'b1;
      frame_data = 64'hAAAAAAAAAAAAAAAA;
      @(negedge clk);
      frame_data = 64'h8040201008040201;
      @(negedge clk);
      frame_req = 1'b0;
      wait_fd(fd0 + 1, "lastwins_frame_done");
      repeat (10) @(negedge clk);
      check("lastwins_one_frame_done", 64'(fd_cnt), 64'(fd0 + 1));
      check("lastwins_queue_empty", 64'(exp_q.size()), 64'd0);

      // spi_busy held while the scheduler waits to send the address byte.
      push_word(8'h0A, 8'h07);
      @(negedge clk);
      int_req   = 1'b1;
      int_value = 4'h7;
      @(negedge clk);
      int_req = 1'b0;
      n = 0;
      while (load_n && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("hold_load_n_fell", 64'(load_n), 64'd0);
      hold_busy = 1'b1;
      saved     = spi_data;
      bad_start = 1'b0;
      bad_data  = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (spi_start) bad_start = 1'b1;
         if (spi_data != saved) bad_data = 1'b1;
      end
      check("hold_no_start", 64'(bad_start), 64'd0);
      check("hold_data_stable", 64'(bad_data), 64'd0);
      hold_busy = 1'b0;
      @(negedge clk);
      check("hold_start_on_release", 64'(spi_start), 64'd1);
      check("hold_addr_on_release", 64'(spi_data), 64'h0A);
      n = 0;
      while (sched_busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("hold_back_idle", 64'(sched_busy), 64'd0);
      check("hold_queue_empty", 64'(exp_q.size()), 64'd0);

      // Asynchronous reset while the data byte of a word is in flight.
      push_frame(64'h1122334455667788);
      acc0 = acc_cnt;
      pulse_frame(64'h1122334455667788);
      n = 0;
      while (acc_cnt < acc0 + 2 && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      check("midword_load_n_low", 64'(load_n), 64'd0);
      check("midword_start_high", 64'(spi_start), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_load_n_high", 64'(load_n), 64'd1);
      check("async_start_low", 64'(spi_start), 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      check_reset_values();
      push_init();
      fd0 = fd_cnt;
      #2 rst_n = 1'b1;
      wait_fd(fd0 + 1, "replay_frame_done");
      repeat (5) @(negedge clk);
      check("replay_queue_empty", 64'(exp_q.size()), 64'd0);
      check("replay_init_done", 64'(init_done), 64'd1);
      check("replay_idle", 64'(sched_busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
